// File: rtl/motor_feedback_reader.sv
// motor_feedback_reader
// Avalon-MM slave that counts rising edges on the motor tachometer/encoder
// pulse inputs over a fixed sample window. It publishes the counts of the last
// completed window, together with a window sequence number and per-channel
// overflow flags, so software can poll them.
module motor_feedback_reader #(
    parameter int unsigned NUM_CH        = 6,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned WINDOW_CYCLES = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [2:0]        addr,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [NUM_CH-1:0] GPIO_in
);

    localparam int unsigned      TW      = $clog2(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] prev;
    logic [NUM_CH-1:0] rise;

    logic [NUM_CH-1:0] en_mask;
    logic [NUM_CH-1:0] en_eff;
    logic              ctrl_wr;
    logic              clr;

    logic [TW-1:0]     timer;
    logic              tc;

    logic [CNT_W-1:0]  live_cnt [NUM_CH];
    logic [CNT_W-1:0]  live_nxt [NUM_CH];
    logic [CNT_W-1:0]  snap_cnt [NUM_CH];
    logic [NUM_CH-1:0] live_ovf;
    logic [NUM_CH-1:0] ovf_nxt;
    logic [NUM_CH-1:0] snap_ovf;
    logic [15:0]       seq;

    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign ctrl_wr      = write && (addr == 3'd7);
    assign clr          = ctrl_wr && writedata[8];
    // A channel disabled by a write in this cycle must not count this cycle's edge.
    assign en_eff       = ctrl_wr ? writedata[NUM_CH-1:0] : en_mask;
    assign rise         = sync2 & ~prev;
    assign tc           = (timer == TW'(WINDOW_CYCLES - 1));
    assign unused_wdata = ^{writedata[31:9], writedata[7:NUM_CH]};

    // Two-flop synchroniser plus one delay flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= GPIO_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Channel enable mask, loaded by any write to the control register.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_mask <= '1;
        end else if (ctrl_wr) begin
            en_mask <= writedata[NUM_CH-1:0];
        end
    end

    // Next live count/flag per channel: saturating increment, zero when disabled.
    always_comb begin
        ovf_nxt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            live_nxt[i] = live_cnt[i];
            if (!en_eff[i]) begin
                live_nxt[i] = '0;
            end else if (rise[i] && (live_cnt[i] != CNT_MAX)) begin
                live_nxt[i] = live_cnt[i] + CNT_W'(1);
            end
            ovf_nxt[i] = en_eff[i] && (live_ovf[i] || (live_nxt[i] == CNT_MAX));
        end
    end

    // Window timer, live counters and snapshot registers; clear beats terminal count.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            timer    <= '0;
            live_ovf <= '0;
            snap_ovf <= '0;
            seq      <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                live_cnt[i] <= '0;
                snap_cnt[i] <= '0;
            end
        end else if (tc) begin
            timer    <= '0;
            live_ovf <= '0;
            snap_ovf <= ovf_nxt;
            seq      <= seq + 16'd1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                live_cnt[i] <= '0;
                snap_cnt[i] <= live_nxt[i];
            end
        end else begin
            timer    <= timer + TW'(1);
            live_ovf <= ovf_nxt;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                live_cnt[i] <= live_nxt[i];
            end
        end
    end

    // Read multiplexer over the current (pre-update) register values.
    always_comb begin
        rd_mux = '0;
        case (addr)
            3'd6: begin
                rd_mux[15:0]        = seq;
                rd_mux[16 +: NUM_CH] = snap_ovf;
            end
            3'd7: begin
                rd_mux[NUM_CH-1:0] = en_mask;
            end
            default: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (addr == 3'(i)) begin
                        rd_mux = 32'(snap_cnt[i]);
                    end
                end
            end
        endcase
    end

    // Registered read data: one cycle latency, held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_motor_feedback_reader.sv
// Directed self-checking bench for motor_feedback_reader (WINDOW_CYCLES=100, CNT_W=4).
// ncyc counts clock edges since the last reset/clear release; snapshot k lands on edge 100*k.
module tb_motor_feedback_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [2:0]  addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [5:0]  GPIO_in;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned ncyc = 0;

    motor_feedback_reader #(
        .NUM_CH(6),
        .CNT_W(4),
        .WINDOW_CYCLES(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .read(read),
        .write(write),
        .addr(addr),
        .writedata(writedata),
        .readdata(readdata),
        .GPIO_in(GPIO_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic goto(input int unsigned n);
        while (ncyc < n) tick();
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
        read = 1'b1;
        addr = a;
        tick();
        read = 1'b0;
        chk($sformatf("%s[a%0d]", tag, a), readdata, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        write     = 1'b1;
        addr      = a;
        writedata = d;
        tick();
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic pulse(input logic [5:0] m, input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            GPIO_in = GPIO_in | m;
            repeat (hi) tick();
            GPIO_in = GPIO_in & ~m;
            repeat (lo) tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_b [8];
        reset     = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        addr      = '0;
        writedata = '0;
        GPIO_in   = '0;
        repeat (3) tick();
        reset = 1'b0;
        ncyc  = 0;

        // Reset values
        chk("rst_readdata", readdata, 32'h0);
        for (int a = 0; a < 8; a++) begin
            chk("pre_rd_zero", readdata, 32'h0);
            rd_chk(3'(a), (a == 7) ? 32'h3F : 32'h0, "rst_rd");
        end

        // 10 pulses on channel 2 in window 1
        pulse(6'b000100, 4, 4, 10);
        goto(100);
        exp_b = '{32'd0, 32'd0, 32'd10, 32'd0, 32'd0, 32'd0, 32'h1, 32'h3F};
        for (int a = 0; a < 8; a++) rd_chk(3'(a), exp_b[a], "win1");

        // 20 short pulses on channel 0: saturate at 15 with overflow
        pulse(6'b000001, 2, 2, 20);
        goto(200);
        rd_chk(3'd0, 32'd15, "sat_cnt");
        rd_chk(3'd6, 32'h0001_0002, "sat_status");
        rd_chk(3'd2, 32'd0, "win2_ch2");
        pulse(6'b000001, 4, 4, 3);
        goto(300);
        rd_chk(3'd0, 32'd3, "post_sat_cnt");
        rd_chk(3'd6, 32'h0000_0003, "post_sat_status");

        // Edge registered in the TC cycle belongs to the closing window
        pulse(6'b001000, 4, 4, 1);
        goto(397);
        GPIO_in[3] = 1'b1;
        repeat (4) tick();
        GPIO_in[3] = 1'b0;
        pulse(6'b010000, 4, 4, 1);
        rd_chk(3'd3, 32'd2, "tc_edge_in");
        rd_chk(3'd6, 32'h4, "tc_status");
        goto(500);
        chk("rd_hold", readdata, 32'h4);
        rd_chk(3'd3, 32'd0, "tc_edge_excl");
        rd_chk(3'd4, 32'd1, "win5_ch4");
        rd_chk(3'd6, 32'h5, "win5_status");

        // Clear written in the TC cycle: clear wins
        pulse(6'b000010, 4, 4, 1);
        goto(599);
        wr(3'd7, 32'h0000_013F);
        ncyc = 0;
        rd_chk(3'd6, 32'h0, "clr_status");
        rd_chk(3'd4, 32'd0, "clr_snap");
        rd_chk(3'd7, 32'h3F, "clr_ctrl");
        goto(100);
        rd_chk(3'd6, 32'h1, "clr_next_snap");
        rd_chk(3'd1, 32'd0, "clr_live_drop");

        // Disable channel 0, pulse channels 0 and 1
        wr(3'd7, 32'h0000_003E);
        pulse(6'b000011, 4, 4, 5);
        goto(200);
        rd_chk(3'd0, 32'd0, "mask_ch0");
        rd_chk(3'd1, 32'd5, "mask_ch1");
        rd_chk(3'd7, 32'h3E, "mask_ctrl");
        rd_chk(3'd6, 32'h2, "mask_status");

        // Reset mid-window with live count 5 on channel 1
        pulse(6'b000010, 4, 4, 5);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        ncyc  = 0;
        chk("mid_rst_readdata", readdata, 32'h0);
        for (int a = 0; a < 8; a++) rd_chk(3'(a), (a == 7) ? 32'h3F : 32'h0, "mid_rst_rd");
        goto(98);
        rd_chk(3'd6, 32'h0, "pre_snap");
        rd_chk(3'd6, 32'h0, "same_cycle_rd");
        rd_chk(3'd6, 32'h1, "post_snap");
        rd_chk(3'd1, 32'd0, "rst_discard");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
